// File: rtl/branch_history_table.sv
// Bimodal direction predictor: 2-bit saturating counters indexed by PC.
// Trains from EX-stage resolution and keeps branch/mispredict statistics.
module branch_history_table #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 4,
    parameter int STAT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] lookup_pc,
    output logic                  predict_taken,
    input  logic                  update_valid,
    input  logic [DATA_WIDTH-1:0] update_pc,
    input  logic                  update_taken,
    input  logic                  update_predicted,
    output logic                  mispredict,
    input  logic                  stat_clear,
    output logic [STAT_WIDTH-1:0] branch_count,
    output logic [STAT_WIDTH-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_WIDTH;

    logic [1:0] bht_q [ENTRIES];

    logic [INDEX_WIDTH-1:0] lookup_idx;
    logic [INDEX_WIDTH-1:0] update_idx;
    logic [1:0]             upd_cur;
    logic [1:0]             upd_next;

    assign lookup_idx = lookup_pc[INDEX_WIDTH+1:2];
    assign update_idx = update_pc[INDEX_WIDTH+1:2];

    // No bypass: lookup always sees the registered (pre-update) counter
    assign predict_taken = bht_q[lookup_idx][1];
    assign mispredict    = update_valid & (update_taken ^ update_predicted);

    assign upd_cur = bht_q[update_idx];

    always_comb begin
        upd_next = upd_cur;
        if (update_taken) begin
            if (upd_cur != 2'b11) upd_next = upd_cur + 2'b01;
        end else begin
            if (upd_cur != 2'b00) upd_next = upd_cur - 2'b01;
        end
    end

    // Register array so the whole table resets in a single cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (update_valid) begin
            bht_q[update_idx] <= upd_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stat_clear) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            branch_count     <= branch_count + STAT_WIDTH'(update_valid);
            mispredict_count <= mispredict_count + STAT_WIDTH'(mispredict);
        end
    end

endmodule

// File: tb/tb_branch_history_table.sv
// Directed + random bench for branch_history_table against an
// arithmetic reference model of the counters and statistics.
module tb_branch_history_table;

    localparam int DW  = 32;
    localparam int IW  = 4;
    localparam int SW  = 4;
    localparam int N   = 1 << IW;
    localparam int MOD = 1 << SW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] lookup_pc;
    logic          predict_taken;
    logic          update_valid;
    logic [DW-1:0] update_pc;
    logic          update_taken;
    logic          update_predicted;
    logic          mispredict;
    logic          stat_clear;
    logic [SW-1:0] branch_count;
    logic [SW-1:0] mispredict_count;

    branch_history_table #(
        .DATA_WIDTH (DW),
        .INDEX_WIDTH(IW),
        .STAT_WIDTH (SW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .lookup_pc       (lookup_pc),
        .predict_taken   (predict_taken),
        .update_valid    (update_valid),
        .update_pc       (update_pc),
        .update_taken    (update_taken),
        .update_predicted(update_predicted),
        .mispredict      (mispredict),
        .stat_clear      (stat_clear),
        .branch_count    (branch_count),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: counter strength 0..3 per entry, plain integer counts
    int m_ctr [N];
    int m_bc;
    int m_mc;

    function automatic int ix(input logic [DW-1:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_ctr[i] = 1;
        m_bc = 0;
        m_mc = 0;
    endtask

    // Entered and left 1 time unit after a rising edge
    task automatic step(input logic r, input logic uv,
                        input logic [DW-1:0] upc, input logic ut,
                        input logic up, input logic sc,
                        input logic [DW-1:0] lpc);
        int  i;
        logic exp_mp;
        rst              = r;
        update_valid     = uv;
        update_pc        = upc;
        update_taken     = ut;
        update_predicted = up;
        stat_clear       = sc;
        lookup_pc        = lpc;
        #1;
        exp_mp = uv && (ut != up);
        chk("predict_taken", 32'(predict_taken),
            32'(m_ctr[ix(lpc)] >= 2));
        chk("mispredict", 32'(mispredict), 32'(exp_mp));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (uv) begin
                i = ix(upc);
                if (ut) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                else    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
            if (sc) begin
                m_bc = 0;
                m_mc = 0;
            end else begin
                m_bc = (m_bc + int'(uv)) % MOD;
                m_mc = (m_mc + int'(exp_mp)) % MOD;
            end
        end
        #1;
        chk("branch_count", 32'(branch_count), 32'(m_bc));
        chk("mispredict_count", 32'(mispredict_count), 32'(m_mc));
    endtask

    task automatic sweep();
        for (int k = 0; k < N; k++) begin
            step(0, 0, 0, 0, 0, 0, 32'(k * 4));
        end
    endtask

    initial begin
        rst = 1'b1;
        update_valid = 0;
        update_pc = 0;
        update_taken = 0;
        update_predicted = 0;
        stat_clear = 0;
        lookup_pc = 0;
        @(posedge clk);
        #1;
        model_reset();
        chk("reset_branch_count", 32'(branch_count), 32'd0);
        chk("reset_mispredict_count", 32'(mispredict_count), 32'd0);
        sweep();

        // Taken training on index 2: 01 -> 10 -> 11, then saturate
        step(0, 1, 32'h0040_0008, 1, 0, 0, 32'h0040_0008);
        step(0, 1, 32'h0040_0008, 1, 0, 0, 32'h0040_0008);
        chk("two_upd_bc", 32'(branch_count), 32'd2);
        chk("two_upd_mc", 32'(mispredict_count), 32'd2);
        step(0, 1, 32'h0040_0008, 1, 1, 0, 32'h0040_0008);
        for (int k = 0; k < 4; k++)
            step(0, 1, 32'h08, 0, 1, 0, 32'h08);
        chk("sat_low", 32'(predict_taken), 32'd0);
        for (int k = 0; k < 4; k++)
            step(0, 1, 32'h08, 1, 0, 0, 32'h08);
        chk("sat_high", 32'(predict_taken), 32'd1);

        // Alias 0x04/0x44, no bypass
        step(0, 1, 32'h04, 1, 0, 0, 32'h44);
        step(0, 0, 0, 0, 0, 0, 32'h44);
        step(0, 1, 32'h08, 0, 0, 0, 32'h04);
        step(0, 0, 0, 0, 0, 0, 32'h04);

        // Clear beats a concurrent mispredicting update; table trains
        step(0, 1, 32'h0C, 1, 0, 1, 32'h0C);
        step(0, 0, 0, 0, 0, 0, 32'h0C);
        chk("clear_bc", 32'(branch_count), 32'd0);

        // 16 updates wrap a 4-bit count back to zero
        for (int k = 0; k < MOD; k++)
            step(0, 1, 32'(k * 4), k[0], 0, 0, 32'h10);
        chk("wrap_bc", 32'(branch_count), 32'd0);

        // Reset mid-stream with concurrent update
        step(0, 1, 32'h14, 1, 1, 0, 0);
        step(0, 1, 32'h14, 1, 1, 0, 0);
        step(1, 1, 32'h14, 1, 0, 0, 32'h14);
        sweep();

        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 79) == 0,
                 1'($urandom),
                 $urandom,
                 1'($urandom),
                 1'($urandom),
                 $urandom_range(0, 29) == 0,
                 $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_history_table.md
Name: branch_history_table

Overview:
- Bimodal direction predictor that supplies the `taken` input of the branch predictor in the IF stage.
- Holds 2^INDEX_WIDTH 2-bit saturating counters indexed by PC word-address bits.
- Trains from branch resolution reported by the EX stage.
- Flags direction mispredictions for the hazard/flush unit and keeps branch and mispredict statistics counters for the debug/display path.

Parameters:
- DATA_WIDTH, 32, width of PC inputs.
- INDEX_WIDTH, 4, log2 of table entries (default 16 entries); index = pc[INDEX_WIDTH+1:2].
- STAT_WIDTH, 32, width of each statistics counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- lookup_pc  input  DATA_WIDTH  IF-stage PC to predict.
- predict_taken  output  1  predicted direction for lookup_pc; drives branch predictor `taken`.
- update_valid  input  1  EX stage resolved a conditional branch (beq/bne/bgtz) this cycle; already qualified by stall/flush externally.
- update_pc  input  DATA_WIDTH  PC of the resolved branch.
- update_taken  input  1  actual branch outcome.
- update_predicted  input  1  direction predicted for this branch at fetch, carried down the pipeline.
- mispredict  output  1  direction misprediction this cycle.
- stat_clear  input  1  synchronous clear of statistics counters only.
- branch_count  output  STAT_WIDTH  number of resolved branches since reset/clear.
- mispredict_count  output  STAT_WIDTH  number of mispredictions since reset/clear.

Behaviour:
- Counter encoding:
  - 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
  - Prediction = counter bit 1.
- Reset:
  - While rst=1 at a rising edge, all entries load 01; branch_count and mispredict_count load 0.
  - rst has priority over update_valid and stat_clear.
  - A reset asserted mid-stream discards any concurrent update.
- Lookup:
  - Combinational, zero latency: predict_taken = table[lookup_pc[INDEX_WIDTH+1:2]][1].
  - PC bits [1:0] and bits above INDEX_WIDTH+1 are ignored, so aliasing is permitted.
- Update:
  - On a rising edge with update_valid=1 and rst=0, entry table[update_pc[INDEX_WIDTH+1:2]] becomes:
    - count+1 if update_taken=1, saturating at 11;
    - count-1 if update_taken=0, saturating at 00.
  - Exactly one entry changes per cycle; all others hold.
- Read/write same cycle, same index: no bypass. predict_taken shows the pre-update value that cycle and the updated value from the next cycle.
- mispredict:
  - Combinational: update_valid & (update_taken != update_predicted).
  - Low whenever update_valid=0. The value of rst does not gate it.
- Statistics:
  - On each edge with rst=0:
    - stat_clear=1 → both counters load 0. Clear wins over a simultaneous update, so the count is 0, not 1.
    - Otherwise, branch_count += update_valid and mispredict_count += mispredict.
  - Both wrap modulo 2^STAT_WIDTH (all-ones + 1 → 0) with no sticky overflow.
  - stat_clear never modifies the table.
- Implementation: the table is a register array (no RAM inference) so the whole table resets in one cycle.
- Invariant: mispredict_count ≤ branch_count unless branch_count has wrapped.

Test Plan:
- Reset, then sweep lookup_pc over 0x00–0x3C step 4 → predict_taken=0 for all 16 entries; both counts=0.
- Two updates on pc 0x0040_0008 with update_taken=1, update_predicted=0 → entry index 2 goes 01→10→11. predict_taken for 0x0040_0008 is 1 starting the cycle after the first update. mispredict=1 on both update cycles; branch_count=2, mispredict_count=2.
- Drive index 2 to 11, then apply three not-taken updates → 10, 01, 00, then a fourth not-taken keeps 00 (saturation). Mirror the test with taken updates from 00 to confirm saturation at 11.
- Aliasing and no-bypass:
  - Update pc 0x04 taken while lookup_pc=0x44 (same index 1, INDEX_WIDTH=4) in the same cycle → predict_taken=0 that cycle, 1 the next.
  - Update pc 0x08 → index 1 unchanged.
- Stats corner cases:
  - stat_clear=1 together with a mispredicting update → both counts 0 next cycle; table entry still trains.
  - With STAT_WIDTH=4, 16 updates → branch_count wraps to 0.
- Reset mid-stream: train several entries, assert rst together with update_valid=1 → all entries 01, counts 0, and the concurrent update has no effect.
